sdram_pro_arbit: RTL

SDRAM_PRO_ARBIT -- requirements
Module: sdram_pro_arbit

---
 rtl/sdram_pro_arbit_pkg.sv | 42 ++++
 rtl/sdram_pro_arbit.sv | 106 ++++++++++
 2 files changed

// File: rtl/sdram_pro_arbit_pkg.sv
// Shared SDRAM command encodings, arbiter state encoding and the owner-selection helper.
// Commands are {cs_n, ras_n, cas_n, we_n}.
package sdram_pro_arbit_pkg;

  localparam logic [3:0]  CMD_NOP          = 4'b0111;
  localparam logic [3:0]  CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0]  CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0]  CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0]  CMD_WRITE        = 4'b0100;
  localparam logic [3:0]  CMD_READ         = 4'b0101;
  localparam logic [3:0]  CMD_LOAD_MODE    = 4'b0000;

  localparam logic [1:0]  IDLE_BA   = 2'b11;
  localparam logic [11:0] IDLE_ADDR = 12'hfff;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_ATREF = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [11:0] addr;
  } sdram_bus_t;

  // Refresh always wins; a write/read tie goes to whichever was not served last.
  function automatic state_t pick_owner(input logic atref_req, input logic wr_req,
                                        input logic rd_req, input logic last_rd);
    state_t owner;
    owner = ST_ARBIT;
    if (atref_req)             owner = ST_ATREF;
    else if (wr_req && rd_req) owner = last_rd ? ST_WRITE : ST_READ;
    else if (wr_req)           owner = ST_WRITE;
    else if (rd_req)           owner = ST_READ;
    return owner;
  endfunction

endpackage

// File: rtl/sdram_pro_arbit.sv
// SDRAM bus arbiter: init, then refresh-first arbitration with write/read round-robin.
// Grants are combinational pulses during the single ARBIT cycle that selects an owner.
module sdram_pro_arbit
  import sdram_pro_arbit_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_bank,
  input  logic [11:0] init_addr,
  input  logic        atref_req,
  input  logic        atref_end,
  input  logic [3:0]  atref_cmd,
  input  logic [1:0]  atref_bank,
  input  logic [11:0] atref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_bank,
  input  logic [11:0] wr_addr,
  input  logic [15:0] wr_dq,
  input  logic        wr_dq_oe,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_bank,
  input  logic [11:0] rd_addr,
  output logic        atref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic [2:0]  dbg_state
);

  state_t     r_state;
  logic       r_last_rd;
  logic       r_cke;
  state_t     w_grant;
  sdram_bus_t w_bus;
  logic [15:0] w_dq_out;
  logic        w_dq_oe;

  assign w_grant = pick_owner(atref_req, wr_req, rd_req, r_last_rd);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_INIT;
      r_last_rd <= 1'b1;
      r_cke     <= 1'b0;
    end else begin
      r_cke <= 1'b1;
      case (r_state)
        ST_INIT:  if (init_end) r_state <= ST_ARBIT;
        ST_ARBIT: begin
          r_state <= w_grant;
          if (w_grant == ST_WRITE)     r_last_rd <= 1'b0;
          else if (w_grant == ST_READ) r_last_rd <= 1'b1;
        end
        ST_ATREF: if (atref_end) r_state <= ST_ARBIT;
        ST_WRITE: if (wr_end)    r_state <= ST_ARBIT;
        ST_READ:  if (rd_end)    r_state <= ST_ARBIT;
        default:  r_state <= ST_INIT;
      endcase
    end
  end

  assign atref_en = (r_state == ST_ARBIT) && (w_grant == ST_ATREF);
  assign wr_en    = (r_state == ST_ARBIT) && (w_grant == ST_WRITE);
  assign rd_en    = (r_state == ST_ARBIT) && (w_grant == ST_READ);

  // Bus follows the registered owner with no added latency; INIT covers reset too.
  always_comb begin
    w_bus    = '{cmd: CMD_NOP, ba: IDLE_BA, addr: IDLE_ADDR};
    w_dq_out = 16'h0000;
    w_dq_oe  = 1'b0;
    case (r_state)
      ST_INIT:  w_bus = '{cmd: init_cmd,  ba: init_bank,  addr: init_addr};
      ST_ATREF: w_bus = '{cmd: atref_cmd, ba: atref_bank, addr: atref_addr};
      ST_WRITE: begin
        w_bus    = '{cmd: wr_cmd, ba: wr_bank, addr: wr_addr};
        w_dq_out = wr_dq;
        w_dq_oe  = wr_dq_oe;
      end
      ST_READ:  w_bus = '{cmd: rd_cmd,    ba: rd_bank,    addr: rd_addr};
      default:  ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_bus.cmd;
  assign sdram_ba     = w_bus.ba;
  assign sdram_addr   = w_bus.addr;
  assign sdram_dq_out = w_dq_out;
  assign sdram_dq_oe  = w_dq_oe;
  assign sdram_cke    = r_cke;
  assign dbg_state    = r_state;

endmodule
